svm_decision_unit: RTL and testbench

- Downstream consumer of the SV/test-pixel memory controller. Computes the SVM decision value D = sum over SVs of alpha_i * K(sv_i, x), plus bias.
- Streams one (sv_pixel, x_pixel) pair per handshake and applies the per-SV coefficient. Emits a signed decision plus a class bit for the next cascade stage.

---
 rtl/svm_decision_unit.sv | 184 ++++++++++++++++++
 tb/tb_svm_decision_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/svm_decision_unit.sv
// SVM decision unit: D = sum_i alpha_i * K(sv_i, x) + bias, streamed one pixel pair per beat.
// Define SVM_POLY_KERNEL_EN for the degree-2 polynomial kernel (adds a SQUARE state per SV).
module svm_decision_unit #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 784,
  parameter int NUM_OF_SV     = 87,
  parameter int ALPHA_W       = 16,
  parameter int BIAS_W        = 32,
  parameter int ACC_W         = 64,
  parameter int KSHIFT        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      decision_funct_en,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [XLEN_PIXEL-1:0]     sv_pixel,
  input  logic [XLEN_PIXEL-1:0]     x_test,
  input  logic signed [ALPHA_W-1:0] alpha,
  input  logic signed [BIAS_W-1:0]  bias,
  output logic                      busy,
  output logic                      done,
  output logic signed [ACC_W-1:0]   decision,
  output logic                      class_out
);

`ifdef SVM_POLY_KERNEL_EN
  localparam bit POLY = 1'b1;
`else
  localparam bit POLY = 1'b0;
`endif
  localparam int PP_W   = 2*XLEN_PIXEL;
  localparam int DOT_W  = PP_W + $clog2(NUM_OF_PIXELS);
  localparam int SQ_W   = 2*DOT_W;
  localparam int KER_W  = POLY ? SQ_W - KSHIFT : DOT_W;
  localparam int PROD_W = KER_W + 1 + ALPHA_W;
  localparam int PC_W   = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
  localparam int SC_W   = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DOT,
`ifdef SVM_POLY_KERNEL_EN
    S_SQUARE,
`endif
    S_SCALE,
    S_BIAS,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [DOT_W-1:0]          dot_q, dot_d;
  logic signed [ALPHA_W-1:0] alpha_q, alpha_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [PC_W-1:0]           pix_cnt_q, pix_cnt_d;
  logic [SC_W-1:0]           sv_cnt_q, sv_cnt_d;
  logic signed [ACC_W-1:0]   decision_q, decision_d;
  logic                      class_q, class_d;
  logic                      done_q, done_d;

  logic                      beat, last_pix, last_sv;
  logic [PP_W-1:0]           pix_prod;
  logic [KER_W-1:0]          kernel;
  logic signed [PROD_W-1:0]  prod;

  assign beat     = (state_q == S_DOT) && pix_valid;
  assign last_pix = (pix_cnt_q == PC_W'(NUM_OF_PIXELS-1));
  assign last_sv  = (sv_cnt_q == SC_W'(NUM_OF_SV-1));
  assign pix_prod = PP_W'(sv_pixel) * PP_W'(x_test);

`ifdef SVM_POLY_KERNEL_EN
  logic [SQ_W-1:0]  sq;
  logic [KER_W-1:0] kern_q, kern_d;
  assign sq     = SQ_W'(dot_q) * SQ_W'(dot_q);
  assign kern_d = KER_W'(sq >> KSHIFT);
  assign kernel = kern_q;
`else
  assign kernel = dot_q;
`endif

  // Kernel is unsigned; a zero MSB makes it a non-negative signed operand.
  assign prod = PROD_W'($signed({1'b0, kernel})) * PROD_W'(alpha_q);

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dot_q      <= '0;
      alpha_q    <= '0;
      acc_q      <= '0;
      pix_cnt_q  <= '0;
      sv_cnt_q   <= '0;
      decision_q <= '0;
      class_q    <= 1'b0;
      done_q     <= 1'b0;
`ifdef SVM_POLY_KERNEL_EN
      kern_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dot_q      <= dot_d;
      alpha_q    <= alpha_d;
      acc_q      <= acc_d;
      pix_cnt_q  <= pix_cnt_d;
      sv_cnt_q   <= sv_cnt_d;
      decision_q <= decision_d;
      class_q    <= class_d;
      done_q     <= done_d;
`ifdef SVM_POLY_KERNEL_EN
      if (state_q == S_SQUARE) kern_q <= kern_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (decision_funct_en) state_d = S_DOT;
`ifdef SVM_POLY_KERNEL_EN
      S_DOT:    if (beat && last_pix) state_d = S_SQUARE;
      S_SQUARE: state_d = S_SCALE;
`else
      S_DOT:    if (beat && last_pix) state_d = S_SCALE;
`endif
      S_SCALE:  state_d = last_sv ? S_BIAS : S_DOT;
      S_BIAS:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    dot_d      = dot_q;
    alpha_d    = alpha_q;
    acc_d      = acc_q;
    pix_cnt_d  = pix_cnt_q;
    sv_cnt_d   = sv_cnt_q;
    decision_d = decision_q;
    class_d    = class_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: if (decision_funct_en) begin
        dot_d     = '0;
        acc_d     = '0;
        pix_cnt_d = '0;
        sv_cnt_d  = '0;
      end
      S_DOT: if (beat) begin
        dot_d = dot_q + DOT_W'(pix_prod);
        if (last_pix) begin
          pix_cnt_d = '0;
          alpha_d   = alpha;
        end else begin
          pix_cnt_d = pix_cnt_q + 1'b1;
        end
      end
      S_SCALE: begin
        acc_d = acc_q + ACC_W'(prod);
        dot_d = '0;
        if (!last_sv) sv_cnt_d = sv_cnt_q + 1'b1;
      end
      S_BIAS: acc_d = acc_q + ACC_W'(bias);
      S_DONE: begin
        done_d     = 1'b1;
        decision_d = acc_q;
        class_d    = ~acc_q[ACC_W-1];
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    pix_ready = (state_q == S_DOT);
    busy      = (state_q != S_IDLE);
  end

  assign done      = done_q;
  assign decision  = decision_q;
  assign class_out = class_q;

endmodule

// File: tb/tb_svm_decision_unit.sv
// Scoreboard bench for svm_decision_unit: small instance (P=4,S=2) plus full-width instance (P=784,S=2).
module tb_svm_decision_unit;
  localparam int P  = 4;
  localparam int S  = 2;
  localparam int P2 = 784;
  localparam int S2 = 2;

`ifdef SVM_POLY_KERNEL_EN
  localparam int     LAT1   = S*(P+2)+2;
  localparam int     LAT2   = S2*(P2+2)+2;
  localparam longint E_BASE = -571;
  localparam longint E_POS  = 1142;
  localparam longint E_ZERO = 1104;
`else
  localparam int     LAT1   = S*(P+1)+2;
  localparam int     LAT2   = S2*(P2+1)+2;
  localparam longint E_BASE = -19;
  localparam longint E_POS  = 38;
  localparam longint E_ZERO = 0;
`endif

  typedef struct {
    string  nm;
    longint d;
    bit     c;
    int     lat;
    int     t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  longint last_dec = 0;

  logic               en1 = 0, pv1 = 0, pr1, busy1, done1, cls1;
  logic [7:0]         sv1 = 0, x1 = 0;
  logic signed [15:0] alpha1 = 0;
  logic signed [31:0] bias1 = 0;
  logic signed [63:0] dec1;

  logic               en2 = 0, pv2 = 0, pr2, busy2, done2, cls2;
  logic [7:0]         sv2 = 0, x2 = 0;
  logic signed [15:0] alpha2 = 0;
  logic signed [31:0] bias2 = 0;
  logic signed [63:0] dec2;

  svm_decision_unit #(.NUM_OF_PIXELS(P), .NUM_OF_SV(S), .KSHIFT(0)) u_dut1 (
    .clk(clk), .rst(rst), .decision_funct_en(en1), .pix_valid(pv1), .pix_ready(pr1),
    .sv_pixel(sv1), .x_test(x1), .alpha(alpha1), .bias(bias1),
    .busy(busy1), .done(done1), .decision(dec1), .class_out(cls1));

  svm_decision_unit #(.NUM_OF_SV(S2)) u_dut2 (
    .clk(clk), .rst(rst), .decision_funct_en(en2), .pix_valid(pv2), .pix_ready(pr2),
    .sv_pixel(sv2), .x_test(x2), .alpha(alpha2), .bias(bias2),
    .busy(busy2), .done(done2), .decision(dec2), .class_out(cls2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // Monitors: pop the oldest expectation on every done pulse
  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) fail_now("dut1 unexpected done pulse");
      else begin
        e1 = q1.pop_front();
        check({e1.nm, " decision"}, dec1, e1.d);
        check({e1.nm, " class_out"}, longint'(cls1), longint'(e1.c));
        check({e1.nm, " latency"}, longint'(cyc - e1.t0), longint'(e1.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2) begin
      if (q2.size() == 0) fail_now("dut2 unexpected done pulse");
      else begin
        e2 = q2.pop_front();
        check({e2.nm, " decision"}, dec2, e2.d);
        check({e2.nm, " class_out"}, longint'(cls2), longint'(e2.c));
        check({e2.nm, " latency"}, longint'(cyc - e2.t0), longint'(e2.lat));
      end
    end
  end

  task automatic drain1(input string nm);
    int k = 0;
    while (q1.size() != 0 && k < 200) begin @(negedge clk); k++; end
    if (q1.size() != 0) begin fail_now({nm, " timeout waiting for done"}); q1.delete(); end
    @(negedge clk);
  endtask

  // One run on dut1: all sv pixels 2, x pixels 3, per-SV alpha a0/a1.
  task automatic run1(input string nm, input int a0, input int a1, input int b,
                      input bit stall, input bit glitch, input bit abort,
                      input longint ed, input int lat);
    exp_t e;
    int k;
    @(negedge clk);
    bias1 = 32'(b);
    en1   = 1'b1;
    if (!abort) begin
      e.nm = nm; e.d = ed; e.c = (ed >= 0); e.lat = lat; e.t0 = cyc + 1;
      q1.push_back(e);
    end
    @(negedge clk);
    en1 = 1'b0;
    for (int s = 0; s < S; s++) begin
      for (int p = 0; p < P; p++) begin
        k = 0;
        while (!pr1 && k < 20) begin @(negedge clk); k++; end
        if (!pr1) begin fail_now({nm, " timeout waiting for pix_ready"}); pv1 = 0; return; end
        if (abort && s == 1 && p == 2) begin
          rst = 1'b1;
          pv1 = 1'b0;
          #1;
          check({nm, " reset busy"}, longint'(busy1), 0);
          check({nm, " reset pix_ready"}, longint'(pr1), 0);
          check({nm, " reset decision"}, dec1, 0);
          check({nm, " reset class_out"}, longint'(cls1), 0);
          @(negedge clk);
          rst = 1'b0;
          last_dec = 0;
          return;
        end
        if (s == 0 && p == 1) check({nm, " decision held"}, dec1, last_dec);
        if (stall) begin pv1 = 1'b0; @(negedge clk); end
        pv1    = 1'b1;
        sv1    = 8'd2;
        x1     = 8'd3;
        alpha1 = 16'((s == 0) ? a0 : a1);
        en1    = glitch && s == 0 && p == 2;
        @(negedge clk);
      end
    end
    pv1 = 1'b0;
    en1 = 1'b0;
    drain1(nm);
    last_dec = ed;
  endtask

  initial begin : main
    exp_t   e;
    int     k;
    longint dot2, ker2;

    repeat (3) @(negedge clk);
    check("reset pix_ready", longint'(pr1), 0);
    check("reset busy", longint'(busy1), 0);
    check("reset done", longint'(done1), 0);
    check("reset decision", dec1, 0);
    check("reset class_out", longint'(cls1), 0);
    rst = 1'b0;

    run1("basic",    1, -2,   5, 0, 0, 0, E_BASE, LAT1);
    run1("positive", 1,  1, -10, 0, 0, 0, E_POS,  LAT1);
    run1("zero",     1,  1, -48, 0, 0, 0, E_ZERO, LAT1);
    run1("stall",    1, -2,   5, 1, 0, 0, E_BASE, LAT1 + 8);
    run1("abort",    1, -2,   5, 0, 0, 1, 0,      0);
    run1("fresh",    1, -2,   5, 0, 0, 0, E_BASE, LAT1);
    run1("glitch",   1,  1, -10, 0, 1, 0, E_POS,  LAT1);

    // Pixel beats offered while idle must be refused and not accumulated
    @(negedge clk);
    pv1 = 1'b1; sv1 = 8'd200; x1 = 8'd200; alpha1 = 16'sd100;
    @(negedge clk);
    check("idle pix_ready", longint'(pr1), 0);
    check("idle busy", longint'(busy1), 0);
    repeat (3) @(negedge clk);
    pv1 = 1'b0;
    run1("after idle beats", 1, 1, -10, 0, 0, 0, E_POS, LAT1);

    // Full-width instance: all pixels 255, alpha 32767, bias 0
    dot2 = longint'(P2) * 255 * 255;
`ifdef SVM_POLY_KERNEL_EN
    ker2 = (dot2 * dot2) >>> 16;
`else
    ker2 = dot2;
`endif
    @(negedge clk);
    en2 = 1'b1; bias2 = '0;
    e.nm = "full width"; e.d = ker2 * 32767 * S2; e.c = 1'b1; e.lat = LAT2; e.t0 = cyc + 1;
    q2.push_back(e);
    @(negedge clk);
    en2 = 1'b0;
    for (int s = 0; s < S2; s++) begin
      for (int p = 0; p < P2; p++) begin
        k = 0;
        while (!pr2 && k < 20) begin @(negedge clk); k++; end
        if (!pr2) fail_now("full width timeout waiting for pix_ready");
        pv2 = 1'b1; sv2 = 8'd255; x2 = 8'd255; alpha2 = 16'sd32767;
        @(negedge clk);
      end
    end
    pv2 = 1'b0;
    k = 0;
    while (q2.size() != 0 && k < 200) begin @(negedge clk); k++; end
    if (q2.size() != 0) fail_now("full width timeout waiting for done");
    check("full width decision positive", longint'(dec2 > 0), 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
